// File: rtl/alu_serial_sequencer.sv
// Bit-serial command master for a 1-bit Alu slice.
// It drives the operands LSB first and keeps the carry locally, so the slice's half-add becomes a full ripple add.
module alu_serial_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  input  logic [0:1]       OP,
  input  logic [WIDTH-1:0] A_IN,
  input  logic [WIDTH-1:0] B_IN,
  output logic             ALU_A,
  output logic             ALU_B,
  output logic [0:1]       ALU_COMMAND,
  input  logic             ALU_RES,
  input  logic             ALU_CARRY,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] RESULT,
  output logic             COUT,
  output logic             ZERO
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] a_sh, b_sh, res_sh;
  logic [0:1]       op_reg;
  logic             c;
  logic [CW-1:0]    cnt;

  logic             accept, last_bit, is_sum, bit_r, c_next;
  logic [WIDTH-1:0] res_next;

  assign is_sum   = (op_reg == 2'b11);
  assign bit_r    = is_sum ? (ALU_RES ^ c) : ALU_RES;
  assign c_next   = ALU_CARRY | (ALU_RES & c);
  assign res_next = {bit_r, res_sh[WIDTH-1:1]};

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next  = state;
    accept      = 1'b0;
    last_bit    = 1'b0;
    ALU_A       = 1'b0;
    ALU_B       = 1'b0;
    ALU_COMMAND = 2'b00;
    BUSY        = 1'b0;
    DONE        = 1'b0;
    case (state)
      S_IDLE: begin
        if (START) begin
          accept     = 1'b1;
          state_next = S_RUN;
        end
      end
      S_RUN: begin
        BUSY        = 1'b1;
        ALU_A       = a_sh[0];
        ALU_B       = b_sh[0];
        ALU_COMMAND = op_reg;
        if (cnt == LAST) begin
          last_bit   = 1'b1;
          state_next = S_DONE;
        end
      end
      S_DONE: begin
        BUSY       = 1'b1;
        DONE       = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Reported outputs only move on the DONE-entry edge so they stay stable across the next RUN.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      op_reg <= '0;
      c      <= 1'b0;
      cnt    <= '0;
      RESULT <= '0;
      COUT   <= 1'b0;
      ZERO   <= 1'b0;
    end else if (accept) begin
      a_sh   <= A_IN;
      b_sh   <= B_IN;
      op_reg <= OP;
      c      <= 1'b0;
      cnt    <= '0;
    end else if (state == S_RUN) begin
      a_sh   <= a_sh >> 1;
      b_sh   <= b_sh >> 1;
      res_sh <= res_next;
      cnt    <= cnt + CW'(1);
      if (is_sum) c <= c_next;
      if (last_bit) begin
        RESULT <= res_next;
        COUT   <= is_sum ? c_next : 1'b0;
        ZERO   <= (res_next == '0);
      end
    end
  end

endmodule

// File: tb/tb_alu_serial_sequencer.sv
// Directed self-checking bench for alu_serial_sequencer, with a behavioural 1-bit Alu slice attached.
module tb_alu_serial_sequencer;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] a_in = '0, b_in = '0;
  logic         alu_a, alu_b, alu_res, alu_carry;
  logic [1:0]   alu_cmd;
  logic         busy, done, cout, zero;
  logic [W-1:0] result;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  alu_serial_sequencer #(.WIDTH(W)) dut (
    .CLK(clk), .RST_N(rst_n), .START(start), .OP(op),
    .A_IN(a_in), .B_IN(b_in),
    .ALU_A(alu_a), .ALU_B(alu_b), .ALU_COMMAND(alu_cmd),
    .ALU_RES(alu_res), .ALU_CARRY(alu_carry),
    .BUSY(busy), .DONE(done), .RESULT(result), .COUT(cout), .ZERO(zero)
  );

  always_comb begin
    alu_res   = 1'b0;
    alu_carry = 1'b0;
    case (alu_cmd)
      2'b00: alu_res = ~alu_b;
      2'b01: alu_res = alu_a | alu_b;
      2'b10: alu_res = alu_a & alu_b;
      default: begin
        alu_res   = alu_a ^ alu_b;
        alu_carry = alu_a & alu_b;
      end
    endcase
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issues one request and returns while DONE is high (or after a 20-cycle timeout).
  task automatic run_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        output int lat, output logic [W-1:0] a_seq, output logic [W-1:0] b_seq,
                        output logic cmd_ok, output logic res_held);
    logic [W-1:0] res_before;
    start = 1'b1; op = o; a_in = a; b_in = b;
    step();
    start = 1'b0; a_in = ~a; b_in = ~b; op = ~o;
    res_before = result;
    lat = 0; a_seq = '0; b_seq = '0; cmd_ok = 1'b1; res_held = 1'b1;
    while (!done && lat < 20) begin
      if (lat < W) begin
        a_seq[lat] = alu_a;
        b_seq[lat] = alu_b;
      end
      if (alu_cmd !== o || busy !== 1'b1) cmd_ok = 1'b0;
      if (result !== res_before) res_held = 1'b0;
      step();
      lat++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tests++;
      if ({busy, done, result, cout, zero, alu_a, alu_b, alu_cmd} !== '0) begin
        fails++;
        $display("FAIL reset_outputs cycle %0d: got busy=%b done=%b result=%h cout=%b zero=%b a=%b b=%b cmd=%b, expected all 0",
                 i, busy, done, result, cout, zero, alu_a, alu_b, alu_cmd);
      end
      step();
    end
  endtask

  task automatic test_sum();
    int lat; logic [W-1:0] as, bs; logic ok, held;
    run_op(2'b11, 8'hB5, 8'h6E, lat, as, bs, ok, held);
    tests++;
    if (lat !== W) begin fails++; $display("FAIL sum_latency got %0d expected %0d", lat, W); end
    tests++;
    if ({result, cout, zero} !== {8'h23, 1'b1, 1'b0}) begin
      fails++; $display("FAIL sum_result got %h/%b/%b expected 23/1/0", result, cout, zero);
    end
    tests++;
    if (ok !== 1'b1) begin fails++; $display("FAIL sum_cmd_in_run got %b expected 1", ok); end
    tests++;
    if ({alu_a, alu_b, alu_cmd} !== 4'b0000) begin
      fails++; $display("FAIL alu_idle_in_done got %b%b%b expected 0000", alu_a, alu_b, alu_cmd);
    end
    step();
    tests++;
    if ({busy, done} !== 2'b00) begin fails++; $display("FAIL done_one_cycle got busy=%b done=%b expected 00", busy, done); end
  endtask

  task automatic test_logic();
    logic [1:0]   ops [3]  = '{2'b10, 2'b01, 2'b00};
    logic [W-1:0] exps [3] = '{8'h24, 8'hFF, 8'h91};
    int lat; logic [W-1:0] as, bs; logic ok, held;
    for (int k = 0; k < 3; k++) begin
      run_op(ops[k], 8'hB5, 8'h6E, lat, as, bs, ok, held);
      tests++;
      if ({result, cout, zero} !== {exps[k], 1'b0, 1'b0}) begin
        fails++; $display("FAIL logic_op%b got %h/%b/%b expected %h/0/0", ops[k], result, cout, zero, exps[k]);
      end
      tests++;
      if ({as, bs} !== {8'hB5, 8'h6E}) begin
        fails++; $display("FAIL logic_bitseq_op%b got a=%h b=%h expected b5/6e", ops[k], as, bs);
      end
      tests++;
      if (ok !== 1'b1 || held !== 1'b1 || lat !== W) begin
        fails++; $display("FAIL logic_run_op%b got cmd_ok=%b held=%b lat=%0d expected 1/1/%0d", ops[k], ok, held, lat, W);
      end
      step();
    end
  endtask

  task automatic test_zero();
    int lat; logic [W-1:0] as, bs; logic ok, held;
    run_op(2'b11, 8'hFF, 8'h01, lat, as, bs, ok, held);
    tests++;
    if ({result, cout, zero} !== {8'h00, 1'b1, 1'b1}) begin
      fails++; $display("FAIL carry_zero got %h/%b/%b expected 00/1/1", result, cout, zero);
    end
    step();
    run_op(2'b10, 8'hF0, 8'h0F, lat, as, bs, ok, held);
    tests++;
    if ({result, cout, zero} !== {8'h00, 1'b0, 1'b1}) begin
      fails++; $display("FAIL and_zero got %h/%b/%b expected 00/0/1", result, cout, zero);
    end
    step();
  endtask

  task automatic test_start_busy();
    int n;
    start = 1'b1; op = 2'b11; a_in = 8'hB5; b_in = 8'h6E;
    step();
    start = 1'b0;
    step(); step();
    start = 1'b1; op = 2'b01; a_in = 8'h00; b_in = 8'h00;
    step();
    start = 1'b0;
    n = 0;
    while (!done && n < 20) begin step(); n++; end
    start = 1'b1; op = 2'b00; a_in = 8'h12; b_in = 8'h34;
    tests++;
    if ({done, result, cout} !== {1'b1, 8'h23, 1'b1}) begin
      fails++; $display("FAIL busy_ignore_run got done=%b result=%h cout=%b expected 1/23/1", done, result, cout);
    end
    step();
    start = 1'b0;
    step();
    tests++;
    if ({busy, result} !== {1'b0, 8'h23}) begin
      fails++; $display("FAIL busy_ignore_done got busy=%b result=%h expected 0/23", busy, result);
    end
  endtask

  task automatic test_back_to_back();
    int t [3];
    int seen = 0;
    start = 1'b1; op = 2'b10; a_in = 8'hB5; b_in = 8'h6E;
    for (int cyc = 0; cyc < 40 && seen < 3; cyc++) begin
      step();
      if (done) begin t[seen] = cyc; seen++; end
    end
    start = 1'b0;
    tests++;
    if (seen !== 3) begin
      fails++; $display("FAIL b2b_pulses got %0d expected 3", seen);
    end else begin
      tests++;
      if ((t[1] - t[0]) !== W + 2 || (t[2] - t[1]) !== W + 2) begin
        fails++; $display("FAIL b2b_spacing got %0d,%0d expected %0d", t[1] - t[0], t[2] - t[1], W + 2);
      end
    end
    for (int i = 0; i < 12; i++) step();
    tests++;
    if (busy !== 1'b0 || result !== 8'h24) begin
      fails++; $display("FAIL b2b_end got busy=%b result=%h expected 0/24", busy, result);
    end
  endtask

  task automatic test_reset_mid_run();
    int lat; logic [W-1:0] as, bs; logic ok, held;
    logic saw_done = 1'b0;
    start = 1'b1; op = 2'b11; a_in = 8'hB5; b_in = 8'h6E;
    step();
    start = 1'b0;
    for (int i = 0; i < 4; i++) step();
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if ({busy, done, result, cout, zero, alu_a, alu_b, alu_cmd} !== '0) begin
      fails++; $display("FAIL async_reset got busy=%b done=%b result=%h cout=%b zero=%b cmd=%b expected all 0",
                        busy, done, result, cout, zero, alu_cmd);
    end
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (done || busy) saw_done = 1'b1;
      step();
    end
    tests++;
    if (saw_done !== 1'b0 || result !== '0) begin
      fails++; $display("FAIL abort_silent got activity=%b result=%h expected 0/00", saw_done, result);
    end
    run_op(2'b11, 8'h01, 8'h01, lat, as, bs, ok, held);
    tests++;
    if ({lat == W, result, cout, zero} !== {1'b1, 8'h02, 1'b0, 1'b0}) begin
      fails++; $display("FAIL after_reset_sum got lat=%0d %h/%b/%b expected %0d 02/0/0", lat, result, cout, zero, W);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_sum();
    test_logic();
    test_zero();
    test_start_busy();
    test_back_to_back();
    test_reset_mid_run();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
